reg_wb_arbiter: RTL and testbench
=================================

# reg_wb_arbiter

Arbitrates the register file's single write port between two writeback requesters: A (ALU result path) and B (memory/load path). Each requester has its own small FIFO and a valid/ready handshake. The block grants one queued write per cycle onto registered `reg_write`/`write_addr`/`write_data` outputs that feed the register file directly. It also exports a per-register pending mask so decode can stall on in-flight writes.

## Interface
Parameters:
- `DATA_W`, default 16: register data width.
- `ADDR_W`, default 3: register address width; the file has 2**ADDR_W registers.
- `DEPTH`, default 2: per-requester FIFO depth; must be a power of two and at least 2.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  requester A offers a write.
- `a_addr`  in  ADDR_W  destination register for A.
- `a_data`  in  DATA_W  write data for A.
- `a_ready`  out  1  A's FIFO is not full.
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same as the A ports, for requester B.
- `stall`  in  1  freeze grants; queued writes are held.
- `reg_write`  out  1  write strobe to the register file (registered).
- `write_addr`  out  ADDR_W  write address (registered).
- `write_data`  out  DATA_W  write data (registered).
- `busy`  out  2**ADDR_W  bit r is set when any write to register r is queued or on the output.

## Operation
- Push: an entry is enqueued into X's FIFO when `x_valid && x_ready` at a rising edge.
- `x_ready = !full_x`, where full means the FIFO holds DEPTH entries. It is a combinational function of state only and never depends on `x_valid`.
- A full FIFO never accepts a push, even when it is popped in the same cycle.
- Grant: at each rising edge with `!stall`, if at least one FIFO is non-empty, the block selects one head, pops it, and registers {1, addr, data} onto the output.
- If both FIFOs are empty, or `stall` is high, `reg_write` is registered as 0. `write_addr` and `write_data` hold their previous values.
- A push and a pop of the same FIFO in one cycle are both legal; the count is unchanged.
- Within one requester, write order is strict FIFO.
- Across requesters, order is grant order. Producers that need ordering between A and B for the same register must use `busy`.
- Arbitration when both heads are valid is selected by `WB_ARB_RR_EN` (see Configuration).
- `busy[r]` = OR over all valid FIFO entries with addr == r, OR (`reg_write` && `write_addr` == r). It is combinational from registered state only.
- Counters and pointers wrap modulo DEPTH.
- Reset, asserted at any time: both FIFOs are flushed and any in-flight output is dropped.

## Timing
- Reset values:
  - `reg_write` = 0, `write_addr` = 0, `write_data` = 0, `busy` = 0.
  - `a_ready` = `b_ready` = 1.
  - Round-robin pointer points to A.
- Latency: a write accepted at edge N is presented on the outputs after edge N+1 at the earliest. The register file commits it at edge N+2.
- Throughput: one write per cycle total, summed across both requesters.
- With `stall` held for K cycles, grants are delayed by exactly K cycles. Queues may still fill during the stall.
- `reg_write` is high for exactly one cycle per granted entry.

## Configuration
- `WB_ARB_RR_EN` defined: round-robin arbitration.
  - The requester granted last has lower priority at the next contention.
  - The pointer updates only on a grant.
- `WB_ARB_RR_EN` undefined: fixed priority, with B (load) always winning over A. The pointer logic is not compiled in.

## Test plan
- Reset, then A pushes (addr 3, data 0x00AA) at edge 1 → at edge 2, `reg_write`=1, `write_addr`=3, `write_data`=0x00AA. `busy[3]` is 1 from after edge 1 until after edge 3.
- Both A (2, 0x1111) and B (5, 0x2222) push at edge 1, with `WB_ARB_RR_EN` defined → A is granted at edge 2 and B at edge 3. With the macro undefined → B is granted first, then A.
- A pushes every cycle with `stall`=1 → after 2 pushes `a_ready`=0 and the third entry is not accepted. Release `stall` → 2 writes come out in push order on consecutive cycles, and `a_ready` returns to 1 after the first pop.
- Push to A and pop from A in the same cycle with the FIFO holding 1 entry → the count stays 1 and the data order is preserved.
- Assert `reset` asynchronously mid-cycle while 3 entries are queued and `reg_write`=1 → the outputs go to 0 immediately, `busy`=0, and no queued write appears after `reset` deasserts.
- Contention with `WB_ARB_RR_EN` defined, both FIFOs kept non-empty for 6 cycles → the grant sequence is A, B, A, B, A, B.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: arbitrates the register-file write port between requester A
// (ALU result) and requester B (load). Each requester has a small FIFO; one
// queued write per cycle is granted onto registered write outputs.
// Build option: define WB_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with B winning over A.
module reg_wb_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [DATA_W-1:0]      b_data,
  output logic                   b_ready,
  input  logic                   stall,
  output logic                   reg_write,
  output logic [ADDR_W-1:0]      write_addr,
  output logic [DATA_W-1:0]      write_data,
  output logic [(2**ADDR_W)-1:0] busy
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [ADDR_W-1:0] a_addr_q [DEPTH];
  logic [DATA_W-1:0] a_data_q [DEPTH];
  logic [ADDR_W-1:0] b_addr_q [DEPTH];
  logic [DATA_W-1:0] b_data_q [DEPTH];
  logic [PW-1:0]     a_rd, a_wr, b_rd, b_wr;
  logic [CW-1:0]     a_cnt, b_cnt;
  logic              a_push, b_push, a_ne, b_ne;
  logic              grant_a, grant_b;

  // Ready depends on occupancy only; a full FIFO never takes a push.
  assign a_ready = (a_cnt != CW'(DEPTH));
  assign b_ready = (b_cnt != CW'(DEPTH));
  assign a_push  = a_valid && a_ready;
  assign b_push  = b_valid && b_ready;
  assign a_ne    = (a_cnt != '0);
  assign b_ne    = (b_cnt != '0);

`ifdef WB_ARB_RR_EN
  logic rr_b;  // 1: B has priority at the next contention

  // Grant selection: the requester granted last yields on contention.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!stall) begin
      grant_a = a_ne && (!b_ne || !rr_b);
      grant_b = b_ne && !grant_a;
    end
  end

  // Round-robin pointer, moved only when a grant happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rr_b <= 1'b0;
    else if (grant_a) rr_b <= 1'b1;
    else if (grant_b) rr_b <= 1'b0;
  end
`else
  // Grant selection: load path always wins over the ALU path.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!stall) begin
      grant_b = b_ne;
      grant_a = a_ne && !b_ne;
    end
  end
`endif

  // FIFO storage; flushing is done through the pointers and counts.
  always_ff @(posedge clk) begin
    if (a_push) begin
      a_addr_q[a_wr] <= a_addr;
      a_data_q[a_wr] <= a_data;
    end
    if (b_push) begin
      b_addr_q[b_wr] <= b_addr;
      b_data_q[b_wr] <= b_data;
    end
  end

  // FIFO pointers and occupancy counts; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rd  <= '0;
      a_wr  <= '0;
      a_cnt <= '0;
      b_rd  <= '0;
      b_wr  <= '0;
      b_cnt <= '0;
    end else begin
      if (a_push)  a_wr <= a_wr + PW'(1);
      if (grant_a) a_rd <= a_rd + PW'(1);
      if (b_push)  b_wr <= b_wr + PW'(1);
      if (grant_b) b_rd <= b_rd + PW'(1);
      a_cnt <= a_cnt + CW'(a_push) - CW'(grant_a);
      b_cnt <= b_cnt + CW'(b_push) - CW'(grant_b);
    end
  end

  // Registered write port; address/data hold when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write  <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      reg_write <= grant_a || grant_b;
      if (grant_b) begin
        write_addr <= b_addr_q[b_rd];
        write_data <= b_data_q[b_rd];
      end else if (grant_a) begin
        write_addr <= a_addr_q[a_rd];
        write_data <= a_data_q[a_rd];
      end
    end
  end

  // Pending-write mask over queued entries plus the write on the output.
  always_comb begin
    logic [PW-1:0] a_idx;
    logic [PW-1:0] b_idx;
    busy = '0;
    if (reg_write) busy[write_addr] = 1'b1;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      a_idx = a_rd + PW'(k);
      b_idx = b_rd + PW'(k);
      if (CW'(k) < a_cnt) busy[a_addr_q[a_idx]] = 1'b1;
      if (CW'(k) < b_cnt) busy[b_addr_q[b_idx]] = 1'b1;
    end
  end

  logic unused_nreg;
  assign unused_nreg = (NREG == 0);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: expected writes are queued at issue and
// a negedge monitor compares every reg_write strobe against the queue head.
module tb_reg_wb_arbiter;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, b_valid, stall;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready;
  logic              reg_write;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [7:0]        busy;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q [$];

  reg_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .stall(stall), .reg_write(reg_write), .write_addr(write_addr),
    .write_data(write_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: every granted write must match the next expected entry.
  always @(negedge clk) begin
    if (!reset && reg_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%h, none expected", write_addr, write_data);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({write_addr, write_data} !== e) begin
          errors++;
          $display("FAIL write_order got addr=%0d data=%h, expected addr=%0d data=%h",
                   write_addr, write_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
    exp_q.push_back({ad, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                       input logic st);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    stall = st;
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    do_reset();
    // Reset state
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_write_addr", 32'(write_addr), 32'd0);
    chk("rst_write_data", 32'(write_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_ready", 32'(b_ready), 32'd1);

    // Single A write: latency and busy window
    drive(1'b1, 3'd3, 16'h00AA, 1'b0, '0, '0, 1'b0);
    expect_wr(3'd3, 16'h00AA);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    chk("t1_busy_after_e1", 32'(busy[3]), 32'd1);
    chk("t1_no_write_e1", 32'(reg_write), 32'd0);
    tick();
    chk("t1_write_e2", 32'(reg_write), 32'd1);
    chk("t1_busy_after_e2", 32'(busy[3]), 32'd1);
    tick();
    chk("t1_busy_after_e3", 32'(busy), 32'd0);
    chk("t1_strobe_one_cycle", 32'(reg_write), 32'd0);

    // Simultaneous A and B push from reset
    do_reset();
    drive(1'b1, 3'd2, 16'h1111, 1'b1, 3'd5, 16'h2222, 1'b0);
`ifdef WB_ARB_RR_EN
    expect_wr(3'd2, 16'h1111);
    expect_wr(3'd5, 16'h2222);
`else
    expect_wr(3'd5, 16'h2222);
    expect_wr(3'd2, 16'h1111);
`endif
    tick();
    chk("t2_busy_both", 32'(busy), 32'h24);
    idle(4);

    // Stall fills A; third push refused; drain in order
    do_reset();
    drive(1'b1, 3'd1, 16'h0301, 1'b0, '0, '0, 1'b1);
    expect_wr(3'd1, 16'h0301);
    tick();
    drive(1'b1, 3'd1, 16'h0302, 1'b0, '0, '0, 1'b1);
    expect_wr(3'd1, 16'h0302);
    tick();
    chk("t3_a_full", 32'(a_ready), 32'd0);
    chk("t3_stalled", 32'(reg_write), 32'd0);
    drive(1'b1, 3'd1, 16'h0303, 1'b0, '0, '0, 1'b1);
    tick();
    chk("t3_still_full", 32'(a_ready), 32'd0);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    chk("t3_first_out", 32'(reg_write), 32'd1);
    chk("t3_ready_back", 32'(a_ready), 32'd1);
    tick();
    chk("t3_second_out", 32'(reg_write), 32'd1);
    idle(3);

    // Push and pop A in the same cycle with one entry held
    do_reset();
    drive(1'b1, 3'd4, 16'h0401, 1'b0, '0, '0, 1'b1);
    expect_wr(3'd4, 16'h0401);
    tick();
    drive(1'b1, 3'd4, 16'h0402, 1'b0, '0, '0, 1'b0);
    expect_wr(3'd4, 16'h0402);
    tick();
    chk("t4_count_one", 32'(a_ready), 32'd1);
    chk("t4_busy4", 32'(busy[4]), 32'd1);
    chk("t4_popped", 32'(reg_write), 32'd1);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    tick();
    chk("t4_drained", 32'(busy), 32'd0);

    // Asynchronous reset mid-cycle with 3 entries queued and a write on the output
    do_reset();
    drive(1'b1, 3'd1, 16'h0501, 1'b1, 3'd2, 16'h0502, 1'b0);
    tick();
    drive(1'b1, 3'd1, 16'h0503, 1'b1, 3'd2, 16'h0504, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    chk("t5_write_active", 32'(reg_write), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_reg_write", 32'(reg_write), 32'd0);
    chk("t5_async_addr", 32'(write_addr), 32'd0);
    chk("t5_async_data", 32'(write_data), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_ready", 32'({a_ready, b_ready}), 32'd3);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(6);
    chk("t5_no_stale_write", 32'(busy), 32'd0);

    // Contention: both FIFOs preloaded under stall, then released
    do_reset();
    drive(1'b1, 3'd1, 16'hA000, 1'b1, 3'd2, 16'hB000, 1'b1);
    tick();
    drive(1'b1, 3'd1, 16'hA001, 1'b1, 3'd2, 16'hB001, 1'b1);
    tick();
    chk("t6_both_full", 32'({a_ready, b_ready}), 32'd0);
`ifdef WB_ARB_RR_EN
    expect_wr(3'd1, 16'hA000); expect_wr(3'd2, 16'hB000);
    expect_wr(3'd1, 16'hA001); expect_wr(3'd2, 16'hB001);
    expect_wr(3'd1, 16'hA002); expect_wr(3'd2, 16'hB002);
    expect_wr(3'd1, 16'hA003); expect_wr(3'd2, 16'hB003);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    drive(1'b1, 3'd1, 16'hA002, 1'b0, '0, '0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 3'd2, 16'hB002, 1'b0);
    tick();
    drive(1'b1, 3'd1, 16'hA003, 1'b0, '0, '0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 3'd2, 16'hB003, 1'b0);
    tick();
    idle(5);
`else
    expect_wr(3'd2, 16'hB000); expect_wr(3'd2, 16'hB001);
    expect_wr(3'd1, 16'hA000); expect_wr(3'd1, 16'hA001);
    idle(6);
`endif
    chk("t6_idle_after", 32'(reg_write), 32'd0);

    // Every expected write must have been observed
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
